ecap5_dwbspi_engine: RTL
========================

# ecap5_dwbspi_engine

SPI master shift engine that sits directly downstream of the ecap5_dwbspi Wishbone register front-end. It takes one byte at a time over a valid/ready handshake, drives the SPI pins in any of the four CPOL/CPHA modes at a programmable SCLK rate, and returns each received byte as a single-cycle pulse. Chip select is handled here so that back-to-back bytes stay inside one frame.

## Interface
- DATA_WIDTH, 8, bits per transfer (≥2)
- clk_i  in  1  system clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-low reset
- cfg_div_i  in  8  SCLK half-period = cfg_div_i+1 clk_i cycles (H)
- cfg_cpol_i  in  1  SCLK idle level
- cfg_cpha_i  in  1  0: sample on leading edge, 1: sample on trailing edge
- cfg_lsb_first_i  in  1  1: bit 0 shifted first
- tx_valid_i  in  1  tx_data_i valid
- tx_ready_o  out  1  engine accepts tx_data_i this cycle
- tx_data_i  in  DATA_WIDTH  byte to transmit
- rx_valid_o  out  1  one-cycle pulse, rx_data_o updated
- rx_data_o  out  DATA_WIDTH  last received byte, held until next pulse
- busy_o  out  1  state ≠ IDLE
- sclk_o, mosi_o, cs_n_o  out  1  SPI pins, all registered
- miso_i  in  1  SPI data in (sampled directly, no synchroniser)

## Operation
- States: IDLE, SETUP, SHIFT, HOLD. All cfg_* inputs are latched on accept and ignored afterwards.
- Accept: tx_valid_i & tx_ready_o. tx_ready_o=1 in IDLE and in the final cycle of HOLD. It is 0 elsewhere.
- IDLE: cs_n_o=1, mosi_o=0, and sclk_o loads cfg_cpol_i every cycle. On accept, go to SETUP.
- SETUP (H cycles): cs_n_o=0, sclk_o=CPOL. If CPHA=0, mosi_o holds the first bit from entry.
- SHIFT (2·DATA_WIDTH·H cycles): sclk_o toggles every H cycles, 2·DATA_WIDTH toggles in total. Odd toggles are leading edges; even toggles are trailing edges.
  - CPHA=0: sample miso_i on the leading edge; drive the next bit on the trailing edge (no drive after the last edge).
  - CPHA=1: drive a bit on the leading edge; sample on the trailing edge.
- HOLD (H cycles): sclk_o=CPOL and cs_n_o stays 0. In the final cycle, rx_valid_o=1 and rx_data_o gets the assembled byte in the same bit order as TX.
  - With an accept in that cycle, go to SETUP with cs_n_o kept 0.
  - Otherwise go to IDLE, with cs_n_o=1 in the next cycle.
- Counters:
  - The divider counter runs 0..cfg_div latched. It wraps at that value, and that wrap is an edge event.
  - The edge counter is $clog2(2·DATA_WIDTH)+1 bits wide.
- Reset (rst_i=0, at any time including mid-transfer) forces IDLE immediately:
  - sclk_o=0, mosi_o=0, cs_n_o=1.
  - tx_ready_o=0 while rst_i=0.
  - rx_valid_o=0, rx_data_o=0, busy_o=0.
  - No rx pulse for an aborted byte.
- Simultaneous rx_valid_o and accept are legal. The rx_data_o of the old byte is valid in that cycle.

## Timing
- Accept at cycle 0.
  - cs_n_o falls at cycle 1.
  - First SCLK edge at cycle 1+H.
  - Edge k at cycle 1+k·H.
  - rx_valid_o in cycle (2·DATA_WIDTH+2)·H.
  - cs_n_o rises at cycle (2·DATA_WIDTH+2)·H+1 if there is no back-to-back accept.
- DATA_WIDTH=8, H=1: 16 edges at cycles 2..17, rx_valid_o at cycle 18.
- Back-to-back period is exactly (2·DATA_WIDTH+2)·H cycles, with cs_n_o continuously low.
- No backpressure on rx; the consumer must take rx_data_o within the frame.

## Test plan
- Mode 0, div=0, tx 0xA5, miso_i looped to mosi_o: sclk rises at cycles 2,4,…,16; rx_valid_o at cycle 18 with rx_data_o=0xA5; cs_n_o high at cycle 19.
- Mode 3, div=2, LSB-first, tx 0x01, miso_i tied 1: mosi_o=1 on the first bit only; sclk idles 1; rx 0xFF at cycle 54.
- Back-to-back 0x12 then 0x34, tx_valid_i held: second accept in cycle 18, cs_n_o never rises between bytes, rx pulses at 18 and 36, second rx_data_o=0x34 in loopback.
- Mode 1 and mode 2, div=0, tx 0x3C, loopback: rx 0x3C. Each sample occurs on the edge given in Operation; checked with an SPI slave model.
- Reset asserted at cycle 7 of a transfer: outputs at their reset values in the same cycle, no rx pulse; after release, a new 0x5A transfer completes correctly.
- div=255 with cfg_div_i changed mid-transfer: each half-period is 256 cycles, unaffected by the change; rx_valid_o at cycle 4608.

Source files
------------

// File: rtl/ecap5_dwbspi_engine.sv
// SPI master shift engine: one DATA_WIDTH word per valid/ready handshake, any CPOL/CPHA mode.
// Latency: accept at cycle 0 -> cs_n low at 1, rx_valid pulse at (2*DATA_WIDTH+2)*(cfg_div+1).
// Backpressure: tx_ready_o only in IDLE and in the last HOLD cycle; rx side has none (single pulse).
module ecap5_dwbspi_engine #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            cfg_div_i,
    input  logic                  cfg_cpol_i,
    input  logic                  cfg_cpha_i,
    input  logic                  cfg_lsb_first_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  rx_valid_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  busy_o,
    output logic                  sclk_o,
    output logic                  mosi_o,
    output logic                  cs_n_o,
    input  logic                  miso_i
);
    localparam int EDGES = 2 * DATA_WIDTH;
    localparam int ECW   = $clog2(EDGES) + 1;
    localparam logic [ECW-1:0] EDGE_LAST = ECW'(EDGES);
    localparam logic [ECW-1:0] EDGE_ONE  = ECW'(1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    state_t                r_state;
    logic [7:0]            r_div;
    logic [7:0]            r_div_cnt;
    logic                  r_cpol;
    logic                  r_cpha;
    logic                  r_lsb;
    logic [ECW-1:0]        r_edge_cnt;
    logic [DATA_WIDTH-1:0] r_tx_sr;
    logic [DATA_WIDTH-1:0] r_rx_sr;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_cs_n;

    logic                  w_tick;
    logic                  w_hold_last;
    logic                  w_ready;
    logic                  w_accept;
    logic [ECW-1:0]        w_next_edge;
    logic                  w_leading;
    logic                  w_do_edge;
    logic                  w_last_next;

    // Bit that leaves the shift register next, honouring the bit order.
    function automatic logic f_out(input logic [DATA_WIDTH-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_WIDTH-1];
    endfunction

    // Drop the bit just sent so the next one sits at the output position.
    function automatic logic [DATA_WIDTH-1:0] f_shift(input logic [DATA_WIDTH-1:0] d, input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    // Insert a received bit so the finished word has the same bit order as TX.
    function automatic logic [DATA_WIDTH-1:0] f_ins(input logic [DATA_WIDTH-1:0] d, input logic b,
                                                    input logic lsb);
        return lsb ? {b, d[DATA_WIDTH-1:1]} : {d[DATA_WIDTH-2:0], b};
    endfunction

    // The divider wrap marks the end of every half-period.
    assign w_tick      = (r_div_cnt == r_div);
    assign w_hold_last = (r_state == S_HOLD) && w_tick;
    assign w_ready     = rst_i && ((r_state == S_IDLE) || w_hold_last);
    assign w_accept    = tx_valid_i && w_ready;
    assign w_next_edge = r_edge_cnt + EDGE_ONE;
    assign w_leading   = w_next_edge[0];
    // SETUP's wrap produces edge 1; SHIFT's wraps produce the rest until all edges are done.
    assign w_do_edge   = w_tick && ((r_state == S_SETUP) ||
                                    ((r_state == S_SHIFT) && (r_edge_cnt != EDGE_LAST)));
    // rx_valid is registered, so raise it one cycle ahead of the final HOLD cycle.
    assign w_last_next = ((r_state == S_SHIFT) && w_tick && (r_edge_cnt == EDGE_LAST) && (r_div == 8'd0)) ||
                         ((r_state == S_HOLD) && (r_div != 8'd0) && (r_div_cnt == r_div - 8'd1));

    // Frame sequencer: state, counters, shift registers and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_div_cnt  <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_edge_cnt <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
        end else begin
            r_rx_valid <= w_last_next;
            if (w_last_next) begin
                r_rx_data <= r_rx_sr;
            end

            if (r_state != S_IDLE) begin
                r_div_cnt <= w_tick ? 8'd0 : r_div_cnt + 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    r_sclk    <= cfg_cpol_i;
                    r_cs_n    <= 1'b1;
                    r_mosi    <= 1'b0;
                    r_div_cnt <= '0;
                end
                S_SETUP: begin
                    if (w_tick) begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_tick && (r_edge_cnt == EDGE_LAST)) begin
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_tick) begin
                        r_state <= S_IDLE;
                        r_cs_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_sclk  <= r_cpol;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_do_edge) begin
                r_sclk     <= ~r_sclk;
                r_edge_cnt <= w_next_edge;
                if (w_leading == !r_cpha) begin
                    r_rx_sr <= f_ins(r_rx_sr, miso_i, r_lsb);
                end else if (r_cpha || (w_next_edge != EDGE_LAST)) begin
                    r_mosi  <= f_out(r_tx_sr, r_lsb);
                    r_tx_sr <= f_shift(r_tx_sr, r_lsb);
                end
            end

            // Accept overrides the IDLE/HOLD defaults; cs_n stays low on back-to-back words.
            if (w_accept) begin
                r_state    <= S_SETUP;
                r_div      <= cfg_div_i;
                r_cpol     <= cfg_cpol_i;
                r_cpha     <= cfg_cpha_i;
                r_lsb      <= cfg_lsb_first_i;
                r_div_cnt  <= '0;
                r_edge_cnt <= '0;
                r_cs_n     <= 1'b0;
                r_sclk     <= cfg_cpol_i;
                if (cfg_cpha_i) begin
                    r_mosi  <= 1'b0;
                    r_tx_sr <= tx_data_i;
                end else begin
                    r_mosi  <= f_out(tx_data_i, cfg_lsb_first_i);
                    r_tx_sr <= f_shift(tx_data_i, cfg_lsb_first_i);
                end
            end
        end
    end

    assign tx_ready_o = w_ready;
    assign rx_valid_o = r_rx_valid;
    assign rx_data_o  = r_rx_data;
    assign busy_o     = (r_state != S_IDLE);
    assign sclk_o     = r_sclk;
    assign mosi_o     = r_mosi;
    assign cs_n_o     = r_cs_n;

endmodule
